// File: rtl/top_if.sv
// top_if -- status bundle of the self-checking tick generator.
//   template_pin  : slow square wave, toggles on every bus wrap
//   template_bus  : 4-bit free-running tick counter
//   sim_success   : run completed with zero self-check errors
//   sim_done      : run completed, pass or fail
//   sim_report    : packed status {state, err_count, bus, tick_count}
//   fault_inj     : observer-side hook; perturbs the shadow compare on a tick
// master = the generator, slave = whoever observes it.
interface top_if;
  logic        template_pin;
  logic [3:0]  template_bus;
  logic        sim_success;
  logic        sim_done;
  logic [31:0] sim_report;
  logic        fault_inj;

  modport master (
    output template_pin, template_bus, sim_success, sim_done, sim_report,
    input  fault_inj
  );
  modport slave (
    input  template_pin, template_bus, sim_success, sim_done, sim_report,
    output fault_inj
  );
endinterface

// File: rtl/top.sv
// top -- prescaled tick counter with an internal shadow self-check.
//   refclk : sole clock, rising edge
//   rst    : synchronous, active-high reset
//   bus    : top_if.master status bundle (see top_if.sv)
// A run lasts RUN_TICKS ticks of PRESCALE refclk cycles each. On the last
// tick the block lands in PASS (no compare errors) or FAIL and stays there
// until reset. All outputs come straight from flops.
module top #(
  parameter int unsigned PRESCALE  = 12,
  parameter int unsigned RUN_TICKS = 256
) (
  input  logic  refclk,
  input  logic  rst,
  top_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] RUN_END = 16'(RUN_TICKS);

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  bus_q, bus_d;
  logic [3:0]  shadow_q, shadow_d;
  logic        pin_q, pin_d;
  logic [15:0] tick_q, tick_d;
  logic [7:0]  err_q, err_d;
  logic        done_q, success_q;
  logic [31:0] report_q;
  logic        tick, mismatch;

  assign tick     = (presc_q == PS_LAST);
  // The observer hook flips the shadow LSB for this compare only, so a
  // single-cycle injection costs exactly one error.
  assign mismatch = (bus_q != (shadow_q ^ {3'b000, bus.fault_inj}));

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? 16'd0 : presc_q + 16'd1;
    bus_d    = bus_q;
    shadow_d = shadow_q;
    pin_d    = pin_q;
    tick_d   = tick_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        // Restart the prescaler phase so the first tick lands exactly
        // PRESCALE cycles into RUN.
        presc_d = 16'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (tick) begin
          bus_d    = bus_q + 4'd1;
          shadow_d = shadow_q + 4'd1;
          tick_d   = tick_q + 16'd1;
          if (bus_q == 4'hF) pin_d = ~pin_q;
          if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          // Verdict includes this tick's compare.
          if (tick_d == RUN_END) state_d = (err_d == 8'd0) ? S_PASS : S_FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      bus_q     <= '0;
      shadow_q  <= '0;
      pin_q     <= 1'b0;
      tick_q    <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
      report_q  <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bus_q     <= bus_d;
      shadow_q  <= shadow_d;
      pin_q     <= pin_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
      // Status flops sample the current state: they trail the verdict by one cycle.
      done_q    <= (state_q == S_PASS) || (state_q == S_FAIL);
      success_q <= (state_q == S_PASS);
      report_q  <= {2'b00, state_q, err_q, bus_q, tick_q};
    end
  end

  assign bus.template_pin = pin_q;
  assign bus.template_bus = bus_q;
  assign bus.sim_done     = done_q;
  assign bus.sim_success  = success_q;
  assign bus.sim_report   = report_q;
endmodule

// File: tb/tb_top.sv
// tb_top -- scoreboard bench for top. Stimulus pushes expected bus changes,
// completion events and timed status probes (absolute cycle numbers) into
// per-DUT queues; a negedge monitor pops and compares as the DUT produces them.
// dut_a: default parameters. dut_b: PRESCALE=2, RUN_TICKS=1.
module tb_top;
  localparam int PA = 12, NA = 256, PB = 2, NB = 1;

  logic refclk = 1'b0;
  logic rst, rstb;
  int   tcyc = 0;
  int   n_chk = 0, n_fail = 0;
  logic end_req = 1'b0, end_ack = 1'b0;

  top_if ifa ();
  top_if ifb ();

  top #(.PRESCALE(PA), .RUN_TICKS(NA)) dut_a (.refclk(refclk), .rst(rst),  .bus(ifa));
  top #(.PRESCALE(PB), .RUN_TICKS(NB)) dut_b (.refclk(refclk), .rst(rstb), .bus(ifb));

  always #5 refclk = ~refclk;
  always @(posedge refclk) tcyc <= tcyc + 1;

  typedef struct { int t; logic [3:0] bus; logic pin; } bev_t;
  typedef struct { int t; logic [31:0] rep; logic done; logic succ; } pev_t;

  bev_t bq[2][$];
  pev_t dq[2][$];
  pev_t pq[2][$];

  logic [3:0]  o_bus[2], p_bus[2];
  logic        o_pin[2], p_pin[2], o_done[2], p_done[2], o_succ[2];
  logic [31:0] o_rep[2];

  assign o_bus[0] = ifa.template_bus;  assign o_bus[1] = ifb.template_bus;
  assign o_pin[0] = ifa.template_pin;  assign o_pin[1] = ifb.template_pin;
  assign o_done[0] = ifa.sim_done;     assign o_done[1] = ifb.sim_done;
  assign o_succ[0] = ifa.sim_success;  assign o_succ[1] = ifb.sim_success;
  assign o_rep[0] = ifa.sim_report;    assign o_rep[1] = ifb.sim_report;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  task automatic push_probe(input int d, input int t, input logic [31:0] rep,
                            input logic done, input logic succ);
    pev_t e;
    e.t = t; e.rep = rep; e.done = done; e.succ = succ;
    pq[d].push_back(e);
  endtask

  task automatic push_done(input int d, input int t, input logic [31:0] rep, input logic succ);
    pev_t e;
    e.t = t; e.rep = rep; e.done = 1'b1; e.succ = succ;
    dq[d].push_back(e);
  endtask

  task automatic push_bev(input int d, input int t, input logic [3:0] b, input logic pin);
    bev_t e;
    e.t = t; e.bus = b; e.pin = pin;
    bq[d].push_back(e);
  endtask

  // Tick j lands on edge j*p+1 after deassert; pin toggles every 16 ticks.
  task automatic push_ticks(input int d, input int t0, input int p, input int nt);
    for (int j = 1; j <= nt; j++) push_bev(d, t0 + j*p + 1, 4'(j % 16), 1'((j / 16) % 2));
  endtask

  task automatic push_early(input int t0);
    push_probe(0, t0 + 1,      32'h0000_0000, 1'b0, 1'b0);
    push_probe(0, t0 + 2,      32'h1000_0000, 1'b0, 1'b0);
    push_probe(0, t0 + PA + 1, 32'h1000_0000, 1'b0, 1'b0);
    push_probe(0, t0 + PA + 2, 32'h1001_0001, 1'b0, 1'b0);
  endtask

  // Full default run: last RUN report just before the verdict, then the
  // completion event and a later probe that it holds.
  task automatic push_full(input int t0, input logic [7:0] err);
    logic [31:0] fin;
    fin = {(err == 8'd0) ? 4'h2 : 4'h3, err, 4'h0, 16'h0100};
    push_early(t0);
    push_ticks(0, t0, PA, NA);
    push_probe(0, t0 + NA*PA + 1,  {4'h1, err, 4'hF, 16'h00FF}, 1'b0, 1'b0);
    push_done (0, t0 + NA*PA + 2,  fin, err == 8'd0);
    push_probe(0, t0 + NA*PA + 60, fin, 1'b1, err == 8'd0);
  endtask

  bev_t b;
  pev_t p;

  always @(negedge refclk) begin
    for (int d = 0; d < 2; d++) begin
      if (tcyc >= 2) begin
        if (o_bus[d] !== p_bus[d] || o_pin[d] !== p_pin[d]) begin
          chk($sformatf("bus_expected%0d", d), 64'(bq[d].size() != 0), 64'd1);
          if (bq[d].size() != 0) begin
            b = bq[d].pop_front();
            chk($sformatf("bus_event%0d", d), {32'(tcyc), 27'd0, o_bus[d], o_pin[d]},
                {32'(b.t), 27'd0, b.bus, b.pin});
          end
        end
        if (o_done[d] === 1'b1 && p_done[d] !== 1'b1) begin
          chk($sformatf("done_expected%0d", d), 64'(dq[d].size() != 0), 64'd1);
          if (dq[d].size() != 0) begin
            p = dq[d].pop_front();
            chk($sformatf("done_cycle%0d", d), 64'(tcyc), 64'(p.t));
            chk($sformatf("done_status%0d", d), {31'd0, o_succ[d], o_rep[d]}, {31'd0, p.succ, p.rep});
          end
        end
      end
      while (pq[d].size() != 0 && pq[d][0].t <= tcyc) begin
        p = pq[d].pop_front();
        if (p.t != tcyc) chk($sformatf("probe_late%0d", d), 64'(tcyc), 64'(p.t));
        chk($sformatf("probe%0d@%0d", d, p.t), {30'd0, o_done[d], o_succ[d], o_rep[d]},
            {30'd0, p.done, p.succ, p.rep});
      end
      p_bus[d]  <= o_bus[d];
      p_pin[d]  <= o_pin[d];
      p_done[d] <= o_done[d];
    end
    if (end_req && !end_ack) begin
      for (int d = 0; d < 2; d++)
        chk($sformatf("drained%0d", d), 64'(bq[d].size() + dq[d].size() + pq[d].size()), 64'd0);
      end_ack <= 1'b1;
    end
  end

  initial begin
    int t0, ta;
    rst = 1'b1; rstb = 1'b1;
    ifa.fault_inj = 1'b0; ifb.fault_inj = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      push_probe(0, t, 32'h0, 1'b0, 1'b0);
      push_probe(1, t, 32'h0, 1'b0, 1'b0);
    end
    repeat (3) @(negedge refclk);

    // Run 1: clean defaults on dut_a; minimal configuration on dut_b.
    rst = 1'b0; rstb = 1'b0; t0 = tcyc;
    push_full(t0, 8'd0);
    push_probe(1, t0 + 1,  32'h0000_0000, 1'b0, 1'b0);
    push_probe(1, t0 + 2,  32'h1000_0000, 1'b0, 1'b0);
    push_probe(1, t0 + 3,  32'h1000_0000, 1'b0, 1'b0);
    push_bev  (1, t0 + 3,  4'd1, 1'b0);
    push_done (1, t0 + 4,  32'h2001_0001, 1'b1);
    push_probe(1, t0 + 20, 32'h2001_0001, 1'b1, 1'b1);
    repeat (NA*PA + 70) @(negedge refclk);

    // Run 2: one injected compare fault mid-run -> FAIL with err_count 1.
    rst = 1'b1; ta = tcyc;
    push_probe(0, ta + 1, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge refclk);
    rst = 1'b0; t0 = tcyc;
    push_full(t0, 8'd1);
    repeat (50*PA + 5) @(negedge refclk);
    ifa.fault_inj = 1'b1;              // held PRESCALE cycles: covers exactly one tick
    repeat (PA) @(negedge refclk);
    ifa.fault_inj = 1'b0;
    repeat (NA*PA + 70 - 51*PA - 5) @(negedge refclk);

    // Run 3: reset after tick 100, then a fresh clean run.
    rst = 1'b1; ta = tcyc;
    push_probe(0, ta + 1, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge refclk);
    rst = 1'b0; t0 = tcyc;
    push_early(t0);
    push_ticks(0, t0, PA, 100);
    repeat (100*PA + 1) @(negedge refclk);
    rst = 1'b1;
    push_bev  (0, t0 + 100*PA + 2, 4'd0, 1'b0);
    push_probe(0, t0 + 100*PA + 2, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge refclk);
    rst = 1'b0; t0 = tcyc;
    push_full(t0, 8'd0);
    repeat (NA*PA + 70) @(negedge refclk);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge refclk);
    if (!end_ack) begin
      $display("FAIL end_handshake: got no monitor ack, required ack within 10 cycles");
      $fatal(1, "monitor did not respond");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Parameters
REQ-001 PRESCALE, 12, refclk cycles per tick; legal 2..65535.
REQ-002 RUN_TICKS, 256, ticks before the block declares the run complete; legal 1..65535.

Interface
REQ-003 refclk  input  1  sole clock; all state updates on its rising edge (nominal 12 MHz).
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 template_pin  output  1  slow square wave; toggles on every bus wrap.
REQ-006 template_bus  output  4  free-running tick counter.
REQ-007 sim_success  output  1  high once the run has completed with zero self-check errors.
REQ-008 sim_done  output  1  high once the run has completed, pass or fail.
REQ-009 sim_report  output  32  packed status word (REQ-019).

Function
REQ-010 Prescaler:
- counts 0..PRESCALE-1 and wraps.
- internal tick is a one-cycle pulse in the cycle the prescaler equals PRESCALE-1.
REQ-011 State machine: IDLE, RUN, PASS, FAIL.
- IDLE -> RUN on the first cycle after rst deasserts.
- RUN -> PASS or FAIL on the tick where tick_count reaches RUN_TICKS.
- PASS and FAIL are terminal until rst.
REQ-012 In RUN, each tick:
- template_bus increments by 1, modulo 16 (15 -> 0 wraps silently).
- tick_count (16-bit) increments by 1.
REQ-013 template_pin toggles on the tick where template_bus changes from 15 to 0; the pin period is 32 ticks.
REQ-014 In IDLE, PASS and FAIL, the prescaler keeps running, but template_bus, template_pin and tick_count hold their values.
REQ-015 Self-check:
- an independent 4-bit shadow counter advances on the same ticks.
- every tick in RUN, the registered template_bus is compared with the shadow value.
- a mismatch increments err_count (8-bit, saturates at 255).
REQ-016 Final state is chosen on the completing tick: PASS if err_count==0 including that tick's compare, else FAIL.
REQ-017 Outputs are registered; they change one cycle after the completing tick:
- sim_done = state in {PASS, FAIL}.
- sim_success = (state==PASS).
REQ-018 All outputs are registered and glitch-free; there are no combinational paths from rst to outputs.
REQ-019 sim_report fields:
- [31:28] state code: IDLE=0, RUN=1, PASS=2, FAIL=3.
- [27:20] err_count.
- [19:16] template_bus.
- [15:0] tick_count.
REQ-020 Latency from rst deassert to sim_done, with defaults: 1 + RUN_TICKS*PRESCALE + 1 = 3074 cycles (about 256 us at 12 MHz).

Reset
REQ-021 While rst is high, on each clock edge:
- state = IDLE.
- prescaler = 0, template_bus = 0, template_pin = 0.
- tick_count = 0, err_count = 0, shadow counter = 0.
- sim_success = 0, sim_done = 0, sim_report = 0.
REQ-022 rst asserted mid-run or after completion returns all of REQ-021 on the next edge; a fresh run starts after deassert.

Verification
REQ-023 rst high 3 cycles then low -> sim_report = 0x0000_0000 during reset; state code becomes 1 one cycle after deassert; first bus increment PRESCALE cycles later.
REQ-024 Run 400 ticks -> template_bus counts 0..15 repeatedly; template_pin toggles exactly when bus goes 15 -> 0, period 32*PRESCALE cycles.
REQ-025 Defaults, no fault -> sim_done rises at cycle 3074 after deassert with sim_success=1 and sim_report=0x2000_0100; both hold until reset.
REQ-026 Force the shadow counter once via a bench-only hook -> at completion sim_done=1, sim_success=0, sim_report[31:28]=3, [27:20]=1.
REQ-027 Assert rst at tick 100, then release -> all outputs clear; completion again occurs 3074 cycles after the new deassert.
REQ-028 PRESCALE=2, RUN_TICKS=1 -> sim_done high 4 cycles after deassert; template_bus=1, tick_count=1.
